// File: rtl/register_writeback_queue.sv
// register_writeback_queue
// Circular FIFO of pending register-file writes {rd, data}. Producers offer
// writes on wb_*, the head entry is written to the register file whenever
// drain_enable is high, and index-0 offers are accepted but dropped.
// Optional bypass lookup is compiled in with the WRITEBACK_BYPASS_EN macro;
// without it the bypass outputs are tied to zero.
module register_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [4:0]    wb_rd,
    input  logic [31:0]   wb_data,
    input  logic          drain_enable,
    output logic          write_enable,
    output logic [4:0]    register_write_select,
    output logic [31:0]   register_data_write,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    output logic          bypass_hit_1,
    output logic          bypass_hit_2,
    output logic [31:0]   bypass_data_1,
    output logic [31:0]   bypass_data_2,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_COUNT = CW'(DEPTH);

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count_q;
    logic          not_empty;
    logic          enqueue;

    assign count     = count_q;
    assign not_empty = (count_q != '0);

    // Ready only when a slot is free; a pop in the same cycle does not open a
    // slot, so a full queue refuses offers even while draining.
    assign wb_ready = !reset && (count_q < DEPTH_COUNT);

    // Index-0 writes are architecturally meaningless: accept, never store.
    assign enqueue = wb_valid && wb_ready && (wb_rd != 5'd0);

    // The register-file write port sees the head entry whenever it is free;
    // nothing is written while reset is asserted.
    assign write_enable          = !reset && not_empty && drain_enable;
    assign register_write_select = not_empty ? rd_mem[head]   : 5'd0;
    assign register_data_write   = not_empty ? data_mem[head] : 32'd0;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (enqueue) begin
                tail <= tail + AW'(1);
            end
            if (write_enable) begin
                head <= head + AW'(1);
            end
            case ({enqueue, write_enable})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clock) begin
        if (enqueue) begin
            rd_mem[tail]   <= wb_rd;
            data_mem[tail] <= wb_data;
        end
    end

`ifdef WRITEBACK_BYPASS_EN
    logic [AW-1:0] scan_idx;

    // Scan stored entries oldest to youngest so the last match (the youngest)
    // wins; the head being drained this cycle still counts as pending.
    always_comb begin
        bypass_hit_1  = 1'b0;
        bypass_hit_2  = 1'b0;
        bypass_data_1 = 32'd0;
        bypass_data_2 = 32'd0;
        scan_idx      = head;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + AW'(k);
            if (CW'(k) < count_q) begin
                if ((rs1 != 5'd0) && (rd_mem[scan_idx] == rs1)) begin
                    bypass_hit_1  = 1'b1;
                    bypass_data_1 = data_mem[scan_idx];
                end
                if ((rs2 != 5'd0) && (rd_mem[scan_idx] == rs2)) begin
                    bypass_hit_2  = 1'b1;
                    bypass_data_2 = data_mem[scan_idx];
                end
            end
        end
    end
`else
    logic unused_bypass_inputs;

    assign unused_bypass_inputs = ^{rs1, rs2};
    assign bypass_hit_1  = 1'b0;
    assign bypass_hit_2  = 1'b0;
    assign bypass_data_1 = 32'd0;
    assign bypass_data_2 = 32'd0;
`endif

endmodule

// File: tb/tb_register_writeback_queue.sv
// Testbench for register_writeback_queue: scenario tasks with inline checks
// plus a scoreboard that predicts every register-file write in order.
module tb_register_writeback_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef WRITEBACK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          wb_valid;
    logic          wb_ready;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          drain_enable;
    logic          write_enable;
    logic [4:0]    register_write_select;
    logic [31:0]   register_data_write;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          bypass_hit_1;
    logic          bypass_hit_2;
    logic [31:0]   bypass_data_1;
    logic [31:0]   bypass_data_2;
    logic [CW-1:0] count;

    int checks;
    int passes;
    logic [36:0] sb[$];

    register_writeback_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .wb_valid              (wb_valid),
        .wb_ready              (wb_ready),
        .wb_rd                 (wb_rd),
        .wb_data               (wb_data),
        .drain_enable          (drain_enable),
        .write_enable          (write_enable),
        .register_write_select (register_write_select),
        .register_data_write   (register_data_write),
        .rs1                   (rs1),
        .rs2                   (rs2),
        .bypass_hit_1          (bypass_hit_1),
        .bypass_hit_2          (bypass_hit_2),
        .bypass_data_1         (bypass_data_1),
        .bypass_data_2         (bypass_data_2),
        .count                 (count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Scoreboard: inputs are stable from just after each rising edge, so at
    // the falling edge compare the DUT against the model, then advance the
    // model exactly as the upcoming rising edge should.
    always @(negedge clock) begin
        logic       exp_we;
        logic       exp_ready;
        logic [36:0] head_entry;
        exp_ready = !reset && (sb.size() < DEPTH);
        exp_we    = !reset && drain_enable && (sb.size() != 0);
        checks++;
        if (write_enable !== exp_we) $display("[TB] FAIL sb_write_enable got=%0b exp=%0b t=%0t", write_enable, exp_we, $time);
        else passes++;
        checks++;
        if (wb_ready !== exp_ready) $display("[TB] FAIL sb_wb_ready got=%0b exp=%0b t=%0t", wb_ready, exp_ready, $time);
        else passes++;
        checks++;
        if (count !== CW'(sb.size())) $display("[TB] FAIL sb_count got=%0d exp=%0d t=%0t", count, sb.size(), $time);
        else passes++;
        if (reset) begin
            sb.delete();
        end else begin
            if (exp_we) begin
                head_entry = sb.pop_front();
                checks++;
                if ({register_write_select, register_data_write} !== head_entry)
                    $display("[TB] FAIL sb_write got=%0d:%h exp=%0d:%h t=%0t", register_write_select, register_data_write, head_entry[36:32], head_entry[31:0], $time);
                else passes++;
            end
            if (wb_valid && exp_ready && (wb_rd != 5'd0)) sb.push_back({wb_rd, wb_data});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (wb_ready !== 1'b0) $display("[TB] FAIL reset_ready got=%0b exp=0", wb_ready);
        else passes++;
        checks++;
        if (write_enable !== 1'b0) $display("[TB] FAIL reset_we got=%0b exp=0", write_enable);
        else passes++;
        tick();
        reset    = 1'b0;
        wb_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0) $display("[TB] FAIL reset_count got=%0d exp=0", count);
        else passes++;
        checks++;
        if ({write_enable, register_write_select, register_data_write} !== 38'd0)
            $display("[TB] FAIL reset_write_port got=%0b:%0d:%h exp=0", write_enable, register_write_select, register_data_write);
        else passes++;
        checks++;
        if ({bypass_hit_1, bypass_hit_2, bypass_data_1, bypass_data_2} !== 66'd0)
            $display("[TB] FAIL reset_bypass got=%0b%0b:%h:%h exp=0", bypass_hit_1, bypass_hit_2, bypass_data_1, bypass_data_2);
        else passes++;
    endtask

    task automatic test_single_write();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; drain_enable = 1'b1;
        tick();
        wb_valid = 1'b0;
        #1;
        checks++;
        if ({write_enable, register_write_select, register_data_write} !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("[TB] FAIL single_write got=%0b:%0d:%h exp=1:5:deadbeef", write_enable, register_write_select, register_data_write);
        else passes++;
        tick();
        checks++;
        if (count !== 3'd0) $display("[TB] FAIL single_count_after got=%0d exp=0", count);
        else passes++;
    endtask

    task automatic test_fill_and_drain();
        drain_enable = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wb_valid = 1'b1; wb_rd = 5'(i); wb_data = 32'h100 * i;
            #1;
            checks++;
            if (wb_ready !== (i <= DEPTH)) $display("[TB] FAIL fill_ready_%0d got=%0b exp=%0b", i, wb_ready, (i <= DEPTH));
            else passes++;
            tick();
        end
        wb_valid = 1'b0;
        checks++;
        if (count !== 3'd4) $display("[TB] FAIL fill_count got=%0d exp=4", count);
        else passes++;
        // Full and draining: the pop must not open a same-cycle slot.
        drain_enable = 1'b1; wb_valid = 1'b1; wb_rd = 5'd20; wb_data = 32'hBAD;
        #1;
        checks++;
        if ({wb_ready, write_enable, register_write_select} !== {1'b0, 1'b1, 5'd1})
            $display("[TB] FAIL full_pop got=%0b:%0b:%0d exp=0:1:1", wb_ready, write_enable, register_write_select);
        else passes++;
        tick();
        wb_valid = 1'b0;
        checks++;
        if (count !== 3'd3) $display("[TB] FAIL full_pop_count got=%0d exp=3", count);
        else passes++;
        for (int i = 2; i <= 4; i++) begin
            #1;
            checks++;
            if ({write_enable, register_write_select} !== {1'b1, 5'(i)})
                $display("[TB] FAIL drain_order_%0d got=%0b:%0d exp=1:%0d", i, write_enable, register_write_select, i);
            else passes++;
            tick();
        end
        checks++;
        if (count !== 3'd0) $display("[TB] FAIL drain_count got=%0d exp=0", count);
        else passes++;
    endtask

    task automatic test_bypass();
        drain_enable = 1'b0; wb_valid = 1'b1;
        wb_rd = 5'd7; wb_data = 32'h11; tick();
        wb_rd = 5'd7; wb_data = 32'h22; tick();
        wb_rd = 5'd9; wb_data = 32'h33; tick();
        // Offer rd=3 stays on the bus (queue not full) but must not be visible.
        wb_rd = 5'd3; wb_data = 32'h44; wb_valid = 1'b0;
        rs1 = 5'd7; rs2 = 5'd0;
        #1;
        checks++;
        if ({bypass_hit_1, bypass_data_1} !== {BYP, BYP ? 32'h22 : 32'h0})
            $display("[TB] FAIL bypass_youngest got=%0b:%h exp=%0b:%h", bypass_hit_1, bypass_data_1, BYP, BYP ? 32'h22 : 32'h0);
        else passes++;
        checks++;
        if ({bypass_hit_2, bypass_data_2} !== 33'd0)
            $display("[TB] FAIL bypass_rs_zero got=%0b:%h exp=0:0", bypass_hit_2, bypass_data_2);
        else passes++;
        rs1 = 5'd3; rs2 = 5'd9; wb_valid = 1'b1;
        #1;
        checks++;
        if ({bypass_hit_1, bypass_hit_2, bypass_data_2} !== {1'b0, BYP, BYP ? 32'h33 : 32'h0})
            $display("[TB] FAIL bypass_miss_and_rs2 got=%0b:%0b:%h exp=0:%0b:%h", bypass_hit_1, bypass_hit_2, bypass_data_2, BYP, BYP ? 32'h33 : 32'h0);
        else passes++;
        // rd=3 offer gets enqueued here; drain head (7:11) at the same time.
        rs1 = 5'd7; drain_enable = 1'b1;
        tick();
        wb_valid = 1'b0; rs1 = 5'd3;
        #1;
        checks++;
        if ({bypass_hit_1, bypass_data_1} !== {BYP, BYP ? 32'h44 : 32'h0})
            $display("[TB] FAIL bypass_after_enqueue got=%0b:%h exp=%0b:%h", bypass_hit_1, bypass_data_1, BYP, BYP ? 32'h44 : 32'h0);
        else passes++;
        tick(); tick(); tick();
        rs1 = 5'd0; rs2 = 5'd0;
        #1;
        checks++;
        if ({count, bypass_hit_2} !== {3'd0, 1'b0}) $display("[TB] FAIL bypass_drained got=%0d:%0b exp=0:0", count, bypass_hit_2);
        else passes++;
    endtask

    task automatic test_rd_zero();
        drain_enable = 1'b1; wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        #1;
        checks++;
        if (wb_ready !== 1'b1) $display("[TB] FAIL rd0_ready got=%0b exp=1", wb_ready);
        else passes++;
        tick();
        wb_valid = 1'b0;
        #1;
        checks++;
        if ({count, write_enable} !== {3'd0, 1'b0}) $display("[TB] FAIL rd0_discard got=%0d:%0b exp=0:0", count, write_enable);
        else passes++;
    endtask

    task automatic test_reset_mid();
        drain_enable = 1'b0; wb_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_rd = 5'(10 + i); wb_data = 32'hA0 + i;
            tick();
        end
        checks++;
        if (count !== 3'd3) $display("[TB] FAIL mid_fill_count got=%0d exp=3", count);
        else passes++;
        reset = 1'b1; wb_rd = 5'd12; drain_enable = 1'b1;
        #1;
        checks++;
        if (write_enable !== 1'b0) $display("[TB] FAIL mid_reset_we got=%0b exp=0", write_enable);
        else passes++;
        tick();
        reset = 1'b0; wb_valid = 1'b0;
        #1;
        checks++;
        if ({count, write_enable} !== {3'd0, 1'b0}) $display("[TB] FAIL mid_reset_after got=%0d:%0b exp=0:0", count, write_enable);
        else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        drain_enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wb_valid = 1'b1; wb_rd = 5'(((i + 25) % 31) + 1); wb_data = $urandom;
            tick();
            checks++;
            if (count !== 3'd1) $display("[TB] FAIL b2b_count_%0d got=%0d exp=1", i, count);
            else passes++;
        end
        wb_valid = 1'b0;
        tick();
        checks++;
        if (count !== 3'd0) $display("[TB] FAIL b2b_final_count got=%0d exp=0", count);
        else passes++;
    endtask

    initial begin
        checks = 0; passes = 0;
        reset = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h12345678;
        drain_enable = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
        test_reset();
        test_single_write();
        test_fill_and_drain();
        test_bypass();
        test_rd_zero();
        test_reset_mid();
        test_back_to_back();
        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/register_writeback_queue.md
REGISTER_WRITEBACK_QUEUE -- requirements
Module: register_writeback_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of pending-write entries (power of two, 2..16).
REQ-002 Parameter: CW, 3, width of count output (log2(DEPTH)+1).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wb_valid  input  1  producer offers a register write this cycle.
REQ-006 wb_ready  output  1  queue accepts the offer this cycle.
REQ-007 wb_rd  input  5  destination register index of the offer.
REQ-008 wb_data  input  32  destination value of the offer.
REQ-009 drain_enable  input  1  register-file write port is available this cycle.
REQ-010 write_enable  output  1  register-file write strobe.
REQ-011 register_write_select  output  5  register-file write index.
REQ-012 register_data_write  output  32  register-file write data.
REQ-013 rs1, rs2  input  5 each  source indices being read from the register file this cycle.
REQ-014 bypass_hit_1, bypass_hit_2  output  1 each  a pending write targets rs1 / rs2.
REQ-015 bypass_data_1, bypass_data_2  output  32 each  youngest pending value for rs1 / rs2.
REQ-016 count  output  CW  number of valid entries.

Function
REQ-017 Queue SHALL be a circular FIFO of DEPTH entries {rd, data} with head/tail pointers wrapping modulo DEPTH.
REQ-018 wb_ready SHALL equal (count < DEPTH) and SHALL be 0 while reset is high.
REQ-019 Accept SHALL occur on the edge where wb_valid && wb_ready; offers with wb_rd == 0 SHALL be accepted and discarded, never enqueued.
REQ-020 write_enable SHALL equal (count != 0) && drain_enable, combinationally; select/data SHALL be the head entry, and SHALL be 0 when count == 0.
REQ-021 Head SHALL pop on the edge where write_enable is 1; one write per cycle maximum.
REQ-022 Simultaneous enqueue and pop SHALL leave count unchanged; order SHALL be preserved (strict FIFO).
REQ-023 Full (count == DEPTH): wb_ready = 0; a pop that cycle SHALL NOT allow same-cycle enqueue.
REQ-024 Empty: write_enable = 0 regardless of drain_enable; an enqueue that cycle SHALL appear at head the next cycle (one-cycle minimum latency offer to write).
REQ-025 Bypass hit SHALL be 1 when any valid entry, including the head being drained that cycle, has rd equal to rsN and rsN != 0; otherwise 0 with data 0.
REQ-026 Multiple matches SHALL return the youngest (closest to tail) entry's data.
REQ-027 The offer on wb_* in the current cycle SHALL NOT participate in bypass (combinational from stored state only).

Reset
REQ-028 With reset high at an edge, count SHALL become 0, head = tail = 0; entries are discarded.
REQ-029 After reset: write_enable = 0, register_write_select = 0, register_data_write = 0, bypass_hit_* = 0, bypass_data_* = 0, count = 0.
REQ-030 Reset mid-operation SHALL drop all pending entries and ignore a coincident wb_valid; no register-file write SHALL occur during a reset cycle.

Configuration
REQ-031 Macro WRITEBACK_BYPASS_EN: defined -> bypass logic per REQ-025..027 compiled in.
REQ-032 Undefined -> bypass_hit_* and bypass_data_* SHALL be tied to 0; all other behaviour identical.

Verification
REQ-033 Reset, then offer rd=5 data=0xDEADBEEF with drain_enable=1 -> next cycle write_enable=1, select=5, data=0xDEADBEEF; following cycle count=0.
REQ-034 drain_enable=0, offer rd=1..5 back-to-back -> four accepted, count=4, wb_ready=0 on fifth; raise drain_enable -> writes issued rd=1,2,3,4 in order on consecutive cycles.
REQ-035 Enqueue rd=7 data=0x11 then rd=7 data=0x22 with drain held off, rs1=7 -> bypass_hit_1=1, bypass_data_1=0x22; rs2=0 -> bypass_hit_2=0.
REQ-036 Offer rd=0 data=0xFFFFFFFF -> wb_ready=1, count stays 0, no write_enable pulse.
REQ-037 With count=3, assert reset for one cycle with wb_valid=1 -> count=0, write_enable=0 next cycle, no entry from the coincident offer.
REQ-038 Steady state drain_enable=1, wb_valid=1 every cycle for 20 cycles with rd cycling 1..31 -> count holds at 1, writes match offers in order, pointers wrap without loss.
